// File: rtl/mem_access_unit_if.sv
// Bundle of the EX-side, data-memory and MEM/WB-side signals of mem_access_unit.
// master: the memory access unit itself; slave: the surrounding pipeline/memory.
interface mem_access_unit_if #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
);
  logic                  in_valid;
  logic                  in_ready;
  logic [XLEN-1:0]       in_alu_res;
  logic [XLEN-1:0]       in_store_data;
  logic                  in_is_load;
  logic                  in_is_store;
  logic [1:0]            in_size;
  logic                  in_unsigned;
  logic                  in_rd_wen;
  logic [REG_ADDR_W-1:0] in_rd_addr;
  logic [XLEN-1:0]       in_pc;

  logic                  dmem_req_valid;
  logic                  dmem_req_ready;
  logic                  dmem_we;
  logic [XLEN-1:0]       dmem_addr;
  logic [XLEN-1:0]       dmem_wdata;
  logic [7:0]            dmem_wmask;
  logic                  dmem_resp_valid;
  logic [XLEN-1:0]       dmem_rdata;

  logic                  out_valid;
  logic                  out_ready;
  logic                  out_rd_wen;
  logic [REG_ADDR_W-1:0] out_rd_addr;
  logic [XLEN-1:0]       out_result;
  logic [XLEN-1:0]       out_pc;
  logic                  out_misalign;
  logic                  busy;

  modport master (
    input  in_valid, in_alu_res, in_store_data, in_is_load, in_is_store,
           in_size, in_unsigned, in_rd_wen, in_rd_addr, in_pc,
    output in_ready,
    output dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    input  dmem_req_ready, dmem_resp_valid, dmem_rdata,
    output out_valid, out_rd_wen, out_rd_addr, out_result, out_pc, out_misalign,
    input  out_ready,
    output busy
  );

  modport slave (
    output in_valid, in_alu_res, in_store_data, in_is_load, in_is_store,
           in_size, in_unsigned, in_rd_wen, in_rd_addr, in_pc,
    input  in_ready,
    input  dmem_req_valid, dmem_we, dmem_addr, dmem_wdata, dmem_wmask,
    output dmem_req_ready, dmem_resp_valid, dmem_rdata,
    input  out_valid, out_rd_wen, out_rd_addr, out_result, out_pc, out_misalign,
    output out_ready,
    input  busy
  );
endinterface

// File: rtl/mem_access_unit.sv
// Memory access stage: turns an EX result into a data-memory load/store,
// aligns load data / store lanes, flags misaligned accesses, and presents one
// registered writeback result per instruction to the MEM/WB register.
module mem_access_unit #(
  parameter int unsigned XLEN       = 64,
  parameter int unsigned REG_ADDR_W = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  mem_access_unit_if.master bus
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT, DONE} state_t;

  state_t state, next_state;

  logic                  accept;
  logic                  rdy;
  logic                  in_mem;
  logic                  in_store_eff;
  logic                  in_aligned;
  logic [2:0]            in_off;

  logic [XLEN-1:0]       r_addr;
  logic [XLEN-1:0]       r_store_data;
  logic [1:0]            r_size;
  logic                  r_unsigned;
  logic                  r_load;
  logic                  r_store;
  logic                  r_rd_wen;
  logic [REG_ADDR_W-1:0] r_rd_addr;
  logic [XLEN-1:0]       r_pc;
  logic                  r_misalign;
  logic [XLEN-1:0]       r_result;

  logic [XLEN-1:0]       rdata_shifted;
  logic [XLEN-1:0]       load_value;
  logic [7:0]            size_mask;

  // Decode of the op currently presented by EX (load wins over store).
  always_comb begin
    in_mem       = bus.in_is_load | bus.in_is_store;
    in_store_eff = bus.in_is_store & ~bus.in_is_load;
    in_off       = bus.in_alu_res[2:0];
    case (bus.in_size)
      2'd0:    in_aligned = 1'b1;
      2'd1:    in_aligned = (in_off[0] == 1'b0);
      2'd2:    in_aligned = (in_off[1:0] == 2'b00);
      default: in_aligned = (in_off == 3'b000);
    endcase
  end

  // State register; reset returns to IDLE at once, abandoning any request.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // Next-state and input handshake; a new accept in DONE overrides the IDLE return.
  always_comb begin
    next_state = state;
    rdy        = 1'b0;
    case (state)
      IDLE: rdy = 1'b1;
      REQ:  if (bus.dmem_req_ready) next_state = WAIT;
      WAIT: if (bus.dmem_resp_valid) next_state = DONE;
      DONE: if (bus.out_ready) begin
              rdy        = 1'b1;
              next_state = IDLE;
            end
    endcase
    accept = bus.in_valid & rdy;
    if (accept) next_state = (in_mem && in_aligned) ? REQ : DONE;
  end

  // Load data alignment and sign/zero extension from the registered access.
  always_comb begin
    rdata_shifted = bus.dmem_rdata >> {r_addr[2:0], 3'b000};
    case (r_size)
      2'd0:    load_value = {{(XLEN-8){~r_unsigned & rdata_shifted[7]}}, rdata_shifted[7:0]};
      2'd1:    load_value = {{(XLEN-16){~r_unsigned & rdata_shifted[15]}}, rdata_shifted[15:0]};
      2'd2:    load_value = {{(XLEN-32){~r_unsigned & rdata_shifted[31]}}, rdata_shifted[31:0]};
      default: load_value = rdata_shifted;
    endcase
    case (r_size)
      2'd0:    size_mask = 8'h01;
      2'd1:    size_mask = 8'h03;
      2'd2:    size_mask = 8'h0F;
      default: size_mask = 8'hFF;
    endcase
  end

  // Capture of the accepted op and the registered writeback value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_addr       <= '0;
      r_store_data <= '0;
      r_size       <= '0;
      r_unsigned   <= 1'b0;
      r_load       <= 1'b0;
      r_store      <= 1'b0;
      r_rd_wen     <= 1'b0;
      r_rd_addr    <= '0;
      r_pc         <= XLEN'(32'h8000_0000);
      r_misalign   <= 1'b0;
      r_result     <= '0;
    end else if (accept) begin
      r_addr       <= bus.in_alu_res;
      r_store_data <= bus.in_store_data;
      r_size       <= bus.in_size;
      r_unsigned   <= bus.in_unsigned;
      r_load       <= bus.in_is_load;
      r_store      <= in_store_eff;
      r_rd_addr    <= bus.in_rd_addr;
      r_pc         <= bus.in_pc;
      r_misalign   <= in_mem & ~in_aligned;
      r_rd_wen     <= bus.in_rd_wen & ~(in_mem & ~in_aligned) & ~in_store_eff;
      r_result     <= (in_mem && in_aligned) ? '0 : bus.in_alu_res;
    end else if (state == WAIT && bus.dmem_resp_valid && r_load) begin
      r_result     <= load_value;
    end
  end

  assign bus.in_ready       = rdy;
  assign bus.dmem_req_valid = (state == REQ);
  assign bus.dmem_we        = (state == REQ) & r_store;
  assign bus.dmem_addr      = {r_addr[XLEN-1:3], 3'b000};
  assign bus.dmem_wdata     = r_store_data << {r_addr[2:0], 3'b000};
  assign bus.dmem_wmask     = (state == REQ && r_store) ? (size_mask << r_addr[2:0]) : '0;
  assign bus.out_valid      = (state == DONE);
  assign bus.out_rd_wen     = r_rd_wen;
  assign bus.out_rd_addr    = r_rd_addr;
  assign bus.out_result     = r_result;
  assign bus.out_pc         = r_pc;
  assign bus.out_misalign   = r_misalign;
  assign bus.busy           = (state != IDLE);

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit: each presented op pushes its expected
// writeback record; records are popped and compared when out_valid is seen.
module tb_mem_access_unit;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  mem_access_unit_if #(.XLEN(64), .REG_ADDR_W(5)) bus ();

  mem_access_unit #(.XLEN(64), .REG_ADDR_W(5)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  typedef struct packed {
    logic [63:0] result;
    logic        rd_wen;
    logic [4:0]  rd_addr;
    logic [63:0] pc;
    logic        misalign;
  } out_t;

  out_t sb[$];
  int   vectors = 0;
  int   miscompares = 0;

  function automatic out_t observed();
    out_t o;
    o.result   = bus.out_result;
    o.rd_wen   = bus.out_rd_wen;
    o.rd_addr  = bus.out_rd_addr;
    o.pc       = bus.out_pc;
    o.misalign = bus.out_misalign;
    return o;
  endfunction

  // Byte-by-byte reference load: gather the accessed bytes, then extend.
  function automatic logic [63:0] exp_load(input logic [63:0] rdata, input logic [2:0] off,
                                           input logic [1:0] size, input logic uns);
    logic [63:0] r = '0;
    int nb = 1 << size;
    for (int i = 0; i < 8; i++)
      if (i < nb && (int'(off) + i) < 8) r[i*8 +: 8] = rdata[(int'(off) + i)*8 +: 8];
    if (!uns && r[nb*8-1])
      for (int i = 0; i < 8; i++) if (i >= nb) r[i*8 +: 8] = 8'hFF;
    return r;
  endfunction

  function automatic logic [7:0] exp_mask(input logic [2:0] off, input logic [1:0] size);
    logic [7:0] m = '0;
    int nb = 1 << size;
    for (int i = 0; i < 8; i++) m[i] = (i >= int'(off)) && (i < int'(off) + nb);
    return m;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive one op on the EX side and push the writeback record it must produce.
  task automatic present(input logic [63:0] addr, input logic [63:0] sdata, input logic ld,
                         input logic st, input logic [1:0] size, input logic uns,
                         input logic rdwen, input logic [4:0] rd, input logic [63:0] pc,
                         input logic [63:0] rdata);
    out_t e;
    int nb = 1 << size;
    bus.in_valid      = 1'b1;
    bus.in_alu_res    = addr;
    bus.in_store_data = sdata;
    bus.in_is_load    = ld;
    bus.in_is_store   = st;
    bus.in_size       = size;
    bus.in_unsigned   = uns;
    bus.in_rd_wen     = rdwen;
    bus.in_rd_addr    = rd;
    bus.in_pc         = pc;
    e.pc = pc;
    e.rd_addr = rd;
    e.misalign = 1'b0;
    if (!(ld || st)) begin
      e.result = addr; e.rd_wen = rdwen;
    end else if ((int'(addr[2:0]) % nb) != 0) begin
      e.result = addr; e.rd_wen = 1'b0; e.misalign = 1'b1;
    end else if (ld) begin
      e.result = exp_load(rdata, addr[2:0], size, uns); e.rd_wen = rdwen;
    end else begin
      e.result = '0; e.rd_wen = 1'b0;
    end
    sb.push_back(e);
  endtask

  // Zero-or-more-wait memory: hold ready low for delay cycles, ack, then respond.
  task automatic serve_mem(input int delay, input logic [63:0] rdata, output bit ok);
    int n = 0;
    while (!bus.dmem_req_valid && n < 20) begin step(); n++; end
    ok = bus.dmem_req_valid;
    if (!ok) return;
    repeat (delay) step();
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_rdata      = rdata;
    step();
    bus.dmem_resp_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    step(); step();
    rst_n = 1'b1;
    step();
    vectors++;
    if ({bus.in_ready, bus.out_valid, bus.busy, bus.dmem_req_valid, bus.dmem_we} !== 5'b10000) begin
      miscompares++;
      $display("FAIL rst_ctl got=%b exp=10000", {bus.in_ready, bus.out_valid, bus.busy, bus.dmem_req_valid, bus.dmem_we});
    end
    vectors++;
    if (bus.dmem_wmask !== 8'h00) begin
      miscompares++; $display("FAIL rst_wmask got=%h exp=00", bus.dmem_wmask);
    end
    vectors++;
    if (observed() !== out_t'{64'h0, 1'b0, 5'd0, 64'h8000_0000, 1'b0}) begin
      miscompares++; $display("FAIL rst_out got=%h exp=pc 80000000, rest 0", observed());
    end
  endtask

  task automatic test_alu();
    out_t e;
    bus.out_ready = 1'b1;
    present(64'h1234, 64'h0, 1'b0, 1'b0, 2'd3, 1'b0, 1'b1, 5'd5, 64'h8000_0100, 64'h0);
    step();
    bus.in_valid = 1'b0;
    vectors++;
    if (bus.out_valid !== 1'b1) begin
      miscompares++; $display("FAIL alu_latency out_valid got=%b exp=1", bus.out_valid);
    end
    e = sb.pop_front();
    vectors++;
    if (observed() !== e) begin
      miscompares++; $display("FAIL alu_out got=%h exp=%h", observed(), e);
    end
    step();
    vectors++;
    if ({bus.busy, bus.out_valid} !== 2'b00) begin
      miscompares++; $display("FAIL alu_idle busy/out_valid got=%b exp=00", {bus.busy, bus.out_valid});
    end
  endtask

  typedef struct packed {
    logic [63:0] addr;
    logic [1:0]  size;
    logic        uns;
    logic        st;
    logic [63:0] rdata;
  } ld_vec_t;

  task automatic test_load();
    ld_vec_t v[9];
    out_t e;
    bit ok;
    v[0] = '{64'h8000_0003, 2'd0, 1'b0, 1'b0, 64'h0000_0000_80FF_0000};
    v[1] = '{64'h8000_0003, 2'd0, 1'b1, 1'b0, 64'h0000_0000_80FF_0000};
    v[2] = '{64'h8000_0002, 2'd0, 1'b0, 1'b0, 64'h0000_0000_80FF_0000};
    v[3] = '{64'h8000_0002, 2'd0, 1'b1, 1'b0, 64'h0000_0000_80FF_0000};
    v[4] = '{64'h8000_0006, 2'd1, 1'b1, 1'b0, 64'h8001_0000_0000_0000};
    v[5] = '{64'h8000_0006, 2'd1, 1'b0, 1'b0, 64'h8001_0000_0000_0000};
    v[6] = '{64'h8000_0004, 2'd2, 1'b0, 1'b0, 64'hF000_0000_1234_5678};
    v[7] = '{64'h8000_0008, 2'd3, 1'b0, 1'b0, 64'h0123_4567_89AB_CDEF};
    v[8] = '{64'h8000_0000, 2'd2, 1'b1, 1'b1, 64'h1111_2222_8765_4321};
    bus.out_ready = 1'b1;
    for (int i = 0; i < 9; i++) begin
      present(v[i].addr, 64'hDEAD_BEEF_DEAD_BEEF, 1'b1, v[i].st, v[i].size, v[i].uns,
              1'b1, 5'(i + 1), 64'h8000_1000 + 64'(i * 4), v[i].rdata);
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.dmem_req_valid, bus.dmem_we, bus.dmem_wmask, bus.dmem_addr, bus.out_valid} !==
          {1'b1, 1'b0, 8'h00, v[i].addr & ~64'h7, 1'b0}) begin
        miscompares++;
        $display("FAIL ld_req[%0d] valid/we/wmask/addr/out_valid got=%b/%b/%h/%h/%b exp=1/0/00/%h/0", i,
                 bus.dmem_req_valid, bus.dmem_we, bus.dmem_wmask, bus.dmem_addr, bus.out_valid, v[i].addr & ~64'h7);
      end
      serve_mem(0, v[i].rdata, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || bus.out_valid !== 1'b1 || observed() !== e) begin
        miscompares++;
        $display("FAIL ld_out[%0d] ok=%0d out_valid=%b got=%h exp=%h", i, ok, bus.out_valid, observed(), e);
      end
      step();
    end
  endtask

  task automatic test_store();
    logic [63:0] sd[4] = '{64'hABCD, 64'h5A, 64'hCAFE_F00D, 64'h0102_0304_0506_0708};
    logic [63:0] ad[4] = '{64'h8000_0006, 64'h8000_0005, 64'h8000_0004, 64'h8000_0010};
    logic [1:0]  sz[4] = '{2'd1, 2'd0, 2'd2, 2'd3};
    out_t e;
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      present(ad[i], sd[i], 1'b0, 1'b1, sz[i], 1'b0, 1'b1, 5'd9, 64'h8000_2000 + 64'(i * 4), 64'h0);
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.dmem_req_valid, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr} !==
          {1'b1, 1'b1, exp_mask(ad[i][2:0], sz[i]), sd[i] << (8 * ad[i][2:0]), ad[i] & ~64'h7}) begin
        miscompares++;
        $display("FAIL st_req[%0d] we=%b wmask=%h wdata=%h addr=%h exp wmask=%h wdata=%h", i,
                 bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr,
                 exp_mask(ad[i][2:0], sz[i]), sd[i] << (8 * ad[i][2:0]));
      end
      if (i == 0) begin
        vectors++;
        if ({bus.dmem_wmask, bus.dmem_wdata} !== {8'hC0, 64'hABCD_0000_0000_0000}) begin
          miscompares++;
          $display("FAIL sh_lanes got=%h/%h exp=c0/abcd000000000000", bus.dmem_wmask, bus.dmem_wdata);
        end
      end
      serve_mem(0, 64'hFFFF_FFFF_FFFF_FFFF, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || bus.out_valid !== 1'b1 || observed() !== e) begin
        miscompares++;
        $display("FAIL st_out[%0d] ok=%0d out_valid=%b got=%h exp=%h", i, ok, bus.out_valid, observed(), e);
      end
      step();
    end
  endtask

  task automatic test_misalign();
    logic [63:0] ad[3] = '{64'h8000_0002, 64'h8000_0004, 64'h8000_0001};
    logic [1:0]  sz[3] = '{2'd2, 2'd3, 2'd1};
    logic        st[3] = '{1'b0, 1'b1, 1'b0};
    out_t e;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      present(ad[i], 64'h77, ~st[i], st[i], sz[i], 1'b0, 1'b1, 5'd3, 64'h8000_3000, 64'h0);
      step();
      bus.in_valid = 1'b0;
      e = sb.pop_front();
      vectors++;
      if (bus.dmem_req_valid !== 1'b0 || bus.out_valid !== 1'b1 || observed() !== e) begin
        miscompares++;
        $display("FAIL misalign[%0d] req_valid=%b out_valid=%b got=%h exp=%h", i,
                 bus.dmem_req_valid, bus.out_valid, observed(), e);
      end
      step();
    end
  endtask

  task automatic test_stall();
    logic [63:0] ad = 64'h8000_0014;
    logic [63:0] sd = 64'hDEAD_BEEF;
    out_t e;
    present(ad, sd, 1'b0, 1'b1, 2'd2, 1'b0, 1'b1, 5'd12, 64'h8000_4000, 64'h0);
    bus.out_ready = 1'b0;
    step();
    bus.in_valid = 1'b0;
    for (int c = 0; c < 4; c++) begin
      vectors++;
      if ({bus.dmem_req_valid, bus.in_ready, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr} !==
          {1'b1, 1'b0, 1'b1, 8'hF0, 64'hDEAD_BEEF_0000_0000, 64'h8000_0010}) begin
        miscompares++;
        $display("FAIL stall_req[%0d] valid=%b in_ready=%b we=%b wmask=%h wdata=%h addr=%h", c,
                 bus.dmem_req_valid, bus.in_ready, bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr);
      end
      if (c < 3) step();
    end
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready  = 1'b0;
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_rdata      = 64'h0;
    step();
    bus.dmem_resp_valid = 1'b0;
    e = sb[0];
    for (int c = 0; c < 2; c++) begin
      vectors++;
      if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || observed() !== e) begin
        miscompares++;
        $display("FAIL stall_out[%0d] out_valid=%b in_ready=%b got=%h exp=%h", c,
                 bus.out_valid, bus.in_ready, observed(), e);
      end
      step();
    end
    bus.out_ready = 1'b1;
    #1;
    e = sb.pop_front();
    vectors++;
    if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || observed() !== e) begin
      miscompares++;
      $display("FAIL stall_release out_valid=%b in_ready=%b got=%h exp=%h", bus.out_valid, bus.in_ready, observed(), e);
    end
    step();
  endtask

  task automatic test_back_to_back();
    out_t e;
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 4)
        present(64'h8000_0001, 64'h0, 1'b1, 1'b0, 2'd1, 1'b0, 1'b1, 5'd20, 64'h8000_5010, 64'h0);
      else if (i == 5)
        present(64'h8000_0020, 64'h0, 1'b1, 1'b0, 2'd2, 1'b1, 1'b1, 5'd21, 64'h8000_5014, 64'h0000_0000_C0DE_0001);
      else
        present(64'h100 * 64'(i + 1), 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'(i % 2), 5'(i + 16),
                64'h8000_5000 + 64'(i * 4), 64'h0);
      if (i > 0) begin
        #1;
        e = sb.pop_front();
        vectors++;
        if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b1 || observed() !== e) begin
          miscompares++;
          $display("FAIL b2b[%0d] out_valid=%b in_ready=%b got=%h exp=%h", i,
                   bus.out_valid, bus.in_ready, observed(), e);
        end
      end
      step();
    end
    bus.in_valid = 1'b0;
    vectors++;
    if ({bus.dmem_req_valid, bus.out_valid} !== 2'b10) begin
      miscompares++; $display("FAIL b2b_to_req req_valid/out_valid got=%b exp=10", {bus.dmem_req_valid, bus.out_valid});
    end
    serve_mem(0, 64'h0000_0000_C0DE_0001, ok);
    e = sb.pop_front();
    vectors++;
    if (!ok || bus.out_valid !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL b2b_load ok=%0d got=%h exp=%h", ok, observed(), e);
    end
    step();
  endtask

  task automatic test_random();
    out_t e;
    bit ok;
    bus.out_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      logic [1:0]  size  = 2'($urandom_range(0, 3));
      int          nb    = 1 << size;
      int          off   = int'($urandom_range(0, 7)) & ~(nb - 1);
      logic [63:0] ad    = 64'h8000_0000 + 64'($urandom_range(0, 255) * 8) + 64'(off);
      logic        ld    = 1'($urandom_range(0, 1));
      logic [63:0] sd    = {$urandom, $urandom};
      logic [63:0] rd    = {$urandom, $urandom};
      logic        uns   = 1'($urandom_range(0, 1));
      present(ad, sd, ld, ~ld, size, uns, 1'b1, 5'($urandom_range(0, 31)), {32'h0, $urandom}, rd);
      step();
      bus.in_valid = 1'b0;
      vectors++;
      if ({bus.dmem_req_valid, bus.dmem_we, bus.dmem_wmask, bus.dmem_addr} !==
          {1'b1, ~ld, ld ? 8'h00 : exp_mask(ad[2:0], size), ad & ~64'h7} ||
          (!ld && bus.dmem_wdata !== (sd << (8 * off)))) begin
        miscompares++;
        $display("FAIL rnd_req[%0d] ld=%b size=%0d off=%0d we=%b wmask=%h wdata=%h addr=%h", i, ld, size, off,
                 bus.dmem_we, bus.dmem_wmask, bus.dmem_wdata, bus.dmem_addr);
      end
      serve_mem(int'($urandom_range(0, 2)), rd, ok);
      e = sb.pop_front();
      vectors++;
      if (!ok || bus.out_valid !== 1'b1 || observed() !== e) begin
        miscompares++;
        $display("FAIL rnd_out[%0d] ok=%0d got=%h exp=%h", i, ok, observed(), e);
      end
      step();
    end
  endtask

  task automatic test_reset_mid();
    out_t e;
    bus.out_ready = 1'b1;
    present(64'h8000_0018, 64'h0, 1'b1, 1'b0, 2'd3, 1'b0, 1'b1, 5'd7, 64'h8000_6000, 64'h0);
    step();
    bus.in_valid = 1'b0;
    bus.dmem_req_ready = 1'b1;
    step();
    bus.dmem_req_ready = 1'b0;
    vectors++;
    if ({bus.busy, bus.dmem_req_valid, bus.out_valid} !== 3'b100) begin
      miscompares++; $display("FAIL rm_wait busy/req/out got=%b exp=100", {bus.busy, bus.dmem_req_valid, bus.out_valid});
    end
    rst_n = 1'b0;
    #1;
    vectors++;
    if ({bus.busy, bus.dmem_req_valid, bus.out_valid, bus.dmem_we, bus.dmem_wmask} !== 12'h0 ||
        observed() !== out_t'{64'h0, 1'b0, 5'd0, 64'h8000_0000, 1'b0}) begin
      miscompares++;
      $display("FAIL rm_async busy=%b req=%b out_valid=%b out=%h exp=all 0, pc 80000000",
               bus.busy, bus.dmem_req_valid, bus.out_valid, observed());
    end
    void'(sb.pop_front());
    step();
    rst_n = 1'b1;
    step();
    bus.dmem_resp_valid = 1'b1;
    bus.dmem_rdata      = 64'hFFFF_0000_FFFF_0000;
    step();
    bus.dmem_resp_valid = 1'b0;
    for (int c = 0; c < 3; c++) begin
      vectors++;
      if ({bus.out_valid, bus.busy, bus.in_ready} !== 3'b001 || bus.out_result !== 64'h0) begin
        miscompares++;
        $display("FAIL rm_stray[%0d] out_valid/busy/in_ready got=%b exp=001 result=%h exp=0", c,
                 {bus.out_valid, bus.busy, bus.in_ready}, bus.out_result);
      end
      step();
    end
    present(64'h55AA, 64'h0, 1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 5'd31, 64'h8000_7000, 64'h0);
    step();
    bus.in_valid = 1'b0;
    e = sb.pop_front();
    vectors++;
    if (bus.out_valid !== 1'b1 || observed() !== e) begin
      miscompares++; $display("FAIL rm_recover out_valid=%b got=%h exp=%h", bus.out_valid, observed(), e);
    end
    step();
  endtask

  initial begin
    bus.in_valid = 1'b0; bus.in_alu_res = '0; bus.in_store_data = '0;
    bus.in_is_load = 1'b0; bus.in_is_store = 1'b0; bus.in_size = '0;
    bus.in_unsigned = 1'b0; bus.in_rd_wen = 1'b0; bus.in_rd_addr = '0; bus.in_pc = '0;
    bus.dmem_req_ready = 1'b0; bus.dmem_resp_valid = 1'b0; bus.dmem_rdata = '0;
    bus.out_ready = 1'b0;
    test_reset();
    test_alu();
    test_load();
    test_store();
    test_misalign();
    test_stall();
    test_back_to_back();
    test_random();
    test_reset_mid();
    vectors++;
    if (sb.size() != 0) begin
      miscompares++; $display("FAIL sb_drain leftover=%0d exp=0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL timeout sim time=%0t limit=500000", $time);
    $fatal(1, "time limit reached");
  end

endmodule
